data_bus_arbiter: RTL and testbench
===================================

Name: data_bus_arbiter

Overview:
- Shares the CPU data bus (SRAM + I/O space, the path used by LD/ST/IN/OUT) between the CPU load/store unit and one external master (DMA / debug port).
- Registered grant FSM with round-robin tie-break and a burst limit so neither master starves.
- Stalls the CPU pipeline while it is not the bus owner.
- Sits between the cpu memory-access stage and the bus_addr/bus_data interconnect.

Parameters:
- DATA_WIDTH, 8, data bus width.
- D_ADDR_WIDTH, 16, data address width.
- MAX_BURST, 4, maximum consecutive granted cycles while the other master is waiting; legal range >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU requests a bus cycle.
- cpu_we  in  1  CPU write (1) / read (0).
- cpu_addr  in  D_ADDR_WIDTH  CPU address.
- cpu_wdata  in  DATA_WIDTH  CPU write data.
- cpu_rdata  out  DATA_WIDTH  read data returned to the CPU.
- cpu_stall  out  1  holds the CPU pipeline.
- ext_req  in  1  external master request.
- ext_we  in  1  external write/read.
- ext_addr  in  D_ADDR_WIDTH  external address.
- ext_wdata  in  DATA_WIDTH  external write data.
- ext_rdata  out  DATA_WIDTH  read data returned to the external master.
- ext_gnt  out  1  external master owns the bus this cycle.
- bus_addr  out  D_ADDR_WIDTH  shared bus address.
- bus_wdata  out  DATA_WIDTH  shared bus write data.
- bus_we  out  1  write strobe.
- bus_re  out  1  read strobe.
- bus_rdata  in  DATA_WIDTH  read data from memory/IO, valid in the same cycle.
- owner  out  2  debug: 00 idle, 01 CPU, 10 EXT.

Behaviour:
- States: IDLE, CPU, EXT. State and owner are registered.
- Counter `burst_cnt` has width $clog2(MAX_BURST)+1.
- Register `last` records the master served most recently.

Reset (reset=0, asynchronous):
- state=IDLE, burst_cnt=0, last=EXT (so the CPU wins the first tie).
- All outputs 0. In particular bus_we and bus_re drop immediately, including mid-transfer.

Latency:
- A request sampled at edge n is granted from edge n onward. Grant is one cycle after the request is raised.

Output decode (combinational from registered state):
- In CPU state, the bus carries cpu_addr/cpu_wdata:
  - bus_we = cpu_req & cpu_we
  - bus_re = cpu_req & ~cpu_we
- In EXT state, the bus carries the ext_* signals in the same way.
- In IDLE, the bus is all zeros.
- cpu_rdata = bus_rdata in CPU state, else 0. ext_rdata follows the same rule for EXT state.
- cpu_stall = cpu_req & (state != CPU).
- ext_gnt = (state == EXT).

Transitions from IDLE:
- Both masters requesting: grant the master that is not `last`.
- Only one requesting: grant that master.
- Neither requesting: stay IDLE.

Transitions from CPU (EXT is symmetric):
- ~cpu_req: go to EXT if ext_req, else IDLE. burst_cnt=0.
- cpu_req & ext_req & burst_cnt==MAX_BURST-1: hand over to EXT with no idle bubble. burst_cnt=0.
- cpu_req & ext_req, limit not reached: stay; burst_cnt++.
- cpu_req & ~ext_req: stay; burst_cnt=0. Ownership is unlimited when uncontested.

Bookkeeping and edge cases:
- `last` updates on every grant into CPU or EXT.
- MAX_BURST=1: under contention, masters strictly alternate every cycle.
- Request dropped and re-raised in the same cycle cannot happen, since requests are level signals sampled once per edge.
- A master may change address/we every cycle while it holds ownership; each granted cycle is one bus transfer.
- CPU with cpu_stall=1 must hold its request stable. The arbiter does not buffer requests.

Test Plan:
1. Reset, then cpu_req=1, cpu_we=1, cpu_addr=0x0026, cpu_wdata=0x03 (OUT 0x06) -> next cycle owner=01, bus_addr=0x0026, bus_wdata=0x03, bus_we=1, cpu_stall=0.
2. cpu_req and ext_req raised together after reset -> CPU granted first. With both held, CPU owns 4 cycles, EXT 4, CPU 4. Ownership switches with no IDLE cycle between owners.
3. Only ext_req=1, ext_we=0, ext_addr=0x0100, bus_rdata=0x5A -> ext_gnt=1, bus_re=1, ext_rdata=0x5A, cpu_rdata=0.
4. EXT owning; cpu_req rises -> cpu_stall=1 until EXT drops or hits 4 cycles, then CPU granted and cpu_stall=0. Set MAX_BURST=1 and repeat -> strict alternation.
5. Drive reset=0 asynchronously mid-write while bus_we=1 -> bus_we=0 and owner=00 before the next clock edge. After release, the first tie goes to the CPU.

Source files
------------

// File: rtl/data_bus_arbiter_if.sv
// Data-bus bundle between the CPU load/store unit, the external master,
// the arbiter and the shared SRAM/IO interconnect.
interface data_bus_arbiter_if #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned D_ADDR_WIDTH = 16
);
    logic                    cpu_req;
    logic                    cpu_we;
    logic [D_ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0]   cpu_wdata;
    logic [DATA_WIDTH-1:0]   cpu_rdata;
    logic                    cpu_stall;

    logic                    ext_req;
    logic                    ext_we;
    logic [D_ADDR_WIDTH-1:0] ext_addr;
    logic [DATA_WIDTH-1:0]   ext_wdata;
    logic [DATA_WIDTH-1:0]   ext_rdata;
    logic                    ext_gnt;

    logic [D_ADDR_WIDTH-1:0] bus_addr;
    logic [DATA_WIDTH-1:0]   bus_wdata;
    logic                    bus_we;
    logic                    bus_re;
    logic [DATA_WIDTH-1:0]   bus_rdata;

    logic [1:0]              owner;

    // Arbiter side
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  ext_req, ext_we, ext_addr, ext_wdata,
        input  bus_rdata,
        output cpu_rdata, cpu_stall, ext_rdata, ext_gnt,
        output bus_addr, bus_wdata, bus_we, bus_re, owner
    );

    // Requesters and memory side
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output ext_req, ext_we, ext_addr, ext_wdata,
        output bus_rdata,
        input  cpu_rdata, cpu_stall, ext_rdata, ext_gnt,
        input  bus_addr, bus_wdata, bus_we, bus_re, owner
    );
endinterface

// File: rtl/data_bus_arbiter.sv
// Two-master data-bus arbiter (CPU load/store vs external DMA/debug) with
// round-robin tie-break and a burst limit under contention.
module data_bus_arbiter #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned D_ADDR_WIDTH = 16,
    parameter int unsigned MAX_BURST    = 4
) (
    input  logic                clk,
    input  logic                reset,
    data_bus_arbiter_if.slave   bus
);
    localparam int unsigned BW = $clog2(MAX_BURST) + 1;
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CPU  = 2'b01,
        S_EXT  = 2'b10
    } state_t;

    typedef enum logic {
        M_CPU = 1'b0,
        M_EXT = 1'b1
    } master_t;

    state_t        state;
    state_t        state_nxt;
    logic [BW-1:0] burst_cnt;
    logic [BW-1:0] burst_cnt_nxt;
    master_t       last;
    master_t       last_nxt;

    // State register; last resets to EXT so the CPU wins the first tie
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            burst_cnt <= '0;
            last      <= M_EXT;
        end else begin
            state     <= state_nxt;
            burst_cnt <= burst_cnt_nxt;
            last      <= last_nxt;
        end
    end

    // Next-state: owner keeps the bus while requesting, yields after MAX_BURST contended cycles
    always_comb begin
        state_nxt     = state;
        burst_cnt_nxt = '0;
        unique case (state)
            S_IDLE: begin
                if (bus.cpu_req && bus.ext_req) begin
                    state_nxt = (last == M_CPU) ? S_EXT : S_CPU;
                end else if (bus.cpu_req) begin
                    state_nxt = S_CPU;
                end else if (bus.ext_req) begin
                    state_nxt = S_EXT;
                end
            end
            S_CPU: begin
                if (!bus.cpu_req) begin
                    state_nxt = bus.ext_req ? S_EXT : S_IDLE;
                end else if (bus.ext_req) begin
                    if (burst_cnt == BURST_LAST) begin
                        state_nxt = S_EXT;
                    end else begin
                        burst_cnt_nxt = burst_cnt + BW'(1);
                    end
                end
            end
            S_EXT: begin
                if (!bus.ext_req) begin
                    state_nxt = bus.cpu_req ? S_CPU : S_IDLE;
                end else if (bus.cpu_req) begin
                    if (burst_cnt == BURST_LAST) begin
                        state_nxt = S_CPU;
                    end else begin
                        burst_cnt_nxt = burst_cnt + BW'(1);
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        last_nxt = last;
        if (state_nxt == S_CPU) begin
            last_nxt = M_CPU;
        end else if (state_nxt == S_EXT) begin
            last_nxt = M_EXT;
        end
    end

    // Output decode from the registered owner; IDLE drives an all-zero bus
    always_comb begin
        bus.bus_addr  = '0;
        bus.bus_wdata = '0;
        bus.bus_we    = 1'b0;
        bus.bus_re    = 1'b0;
        bus.cpu_rdata = '0;
        bus.ext_rdata = '0;
        unique case (state)
            S_CPU: begin
                bus.bus_addr  = bus.cpu_addr;
                bus.bus_wdata = bus.cpu_wdata;
                bus.bus_we    = bus.cpu_req & bus.cpu_we;
                bus.bus_re    = bus.cpu_req & ~bus.cpu_we;
                bus.cpu_rdata = bus.bus_rdata;
            end
            S_EXT: begin
                bus.bus_addr  = bus.ext_addr;
                bus.bus_wdata = bus.ext_wdata;
                bus.bus_we    = bus.ext_req & bus.ext_we;
                bus.bus_re    = bus.ext_req & ~bus.ext_we;
                bus.ext_rdata = bus.bus_rdata;
            end
            default: ;
        endcase
        // Stall is masked while reset is asserted so every output reads 0
        bus.cpu_stall = reset & bus.cpu_req & (state != S_CPU);
        bus.ext_gnt   = (state == S_EXT);
        bus.owner     = state;
    end
endmodule

// File: tb/tb_data_bus_arbiter.sv
// Bench for data_bus_arbiter: directed scenarios plus randomized traffic
// checked against a behavioural ownership model.
module tb_data_bus_arbiter;
    localparam int unsigned DW     = 8;
    localparam int unsigned AW     = 16;
    localparam int          TB_MAX = 4;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    // Model state: owner 0 idle / 1 cpu / 2 ext
    int m_owner;
    int m_run;
    int m_last;

    data_bus_arbiter_if #(.DATA_WIDTH(DW), .D_ADDR_WIDTH(AW)) bif ();
    data_bus_arbiter_if #(.DATA_WIDTH(DW), .D_ADDR_WIDTH(AW)) bif1 ();

    data_bus_arbiter #(.DATA_WIDTH(DW), .D_ADDR_WIDTH(AW), .MAX_BURST(TB_MAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    data_bus_arbiter #(.DATA_WIDTH(DW), .D_ADDR_WIDTH(AW), .MAX_BURST(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bif1)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        bif.cpu_req = 0; bif.cpu_we = 0; bif.cpu_addr = '0; bif.cpu_wdata = '0;
        bif.ext_req = 0; bif.ext_we = 0; bif.ext_addr = '0; bif.ext_wdata = '0;
        bif.bus_rdata = '0;
        bif1.cpu_req = 0; bif1.cpu_we = 0; bif1.cpu_addr = '0; bif1.cpu_wdata = '0;
        bif1.ext_req = 0; bif1.ext_we = 0; bif1.ext_addr = '0; bif1.ext_wdata = '0;
        bif1.bus_rdata = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        idle_inputs();
        reset = 0;
        repeat (2) @(negedge clk);
        reset = 1;
    endtask

    // Behavioural rule: the owner keeps the bus while it asks; once the rival
    // has waited through TB_MAX of the owner's cycles, the rival takes over.
    task automatic model_step(input logic creq, input logic ereq);
        int   other;
        logic mine;
        logic rival;
        if (m_owner == 0) begin
            if (creq && ereq) m_owner = (m_last == 1) ? 2 : 1;
            else if (creq)    m_owner = 1;
            else if (ereq)    m_owner = 2;
            m_run = 0;
        end else begin
            other = 3 - m_owner;
            mine  = (m_owner == 1) ? creq : ereq;
            rival = (m_owner == 1) ? ereq : creq;
            if (!mine) begin
                m_owner = rival ? other : 0;
                m_run   = 0;
            end else if (rival) begin
                m_run = m_run + 1;
                if (m_run == TB_MAX) begin
                    m_owner = other;
                    m_run   = 0;
                end
            end else begin
                m_run = 0;
            end
        end
        if (m_owner != 0) m_last = m_owner;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 0;
        bif.cpu_req = 1; bif.ext_req = 1; bif.cpu_we = 1;
        #1;
        n_cmp++;
        if (bif.owner !== 2'b00) begin
            n_err++; $display("FAIL reset_owner: got %b want 00", bif.owner);
        end
        n_cmp++;
        if ({bif.bus_we, bif.bus_re} !== 2'b00) begin
            n_err++; $display("FAIL reset_strobes: got %b want 00", {bif.bus_we, bif.bus_re});
        end
        n_cmp++;
        if ({bif.cpu_stall, bif.ext_gnt} !== 2'b00) begin
            n_err++; $display("FAIL reset_stall_gnt: got %b want 00", {bif.cpu_stall, bif.ext_gnt});
        end
        n_cmp++;
        if (bif.bus_addr !== 16'h0000) begin
            n_err++; $display("FAIL reset_addr: got %h want 0000", bif.bus_addr);
        end
        apply_reset();
    endtask

    task automatic test_cpu_write();
        apply_reset();
        @(negedge clk);
        bif.cpu_req = 1; bif.cpu_we = 1; bif.cpu_addr = 16'h0026; bif.cpu_wdata = 8'h03;
        #1;
        n_cmp++;
        if (bif.cpu_stall !== 1'b1) begin
            n_err++; $display("FAIL cpuwr_stall_idle: got %b want 1", bif.cpu_stall);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (bif.owner !== 2'b01) begin
            n_err++; $display("FAIL cpuwr_owner: got %b want 01", bif.owner);
        end
        n_cmp++;
        if ({bif.bus_addr, bif.bus_wdata} !== {16'h0026, 8'h03}) begin
            n_err++; $display("FAIL cpuwr_bus: got %h/%h want 0026/03", bif.bus_addr, bif.bus_wdata);
        end
        n_cmp++;
        if ({bif.bus_we, bif.bus_re, bif.cpu_stall} !== 3'b100) begin
            n_err++; $display("FAIL cpuwr_strobes: got %b want 100", {bif.bus_we, bif.bus_re, bif.cpu_stall});
        end
        bif.cpu_req = 0;
        @(negedge clk); #1;
        n_cmp++;
        if (bif.owner !== 2'b00) begin
            n_err++; $display("FAIL cpuwr_release: got %b want 00", bif.owner);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp;
        apply_reset();
        @(negedge clk);
        bif.cpu_req = 1; bif.cpu_we = 0; bif.cpu_addr = 16'h0010;
        bif.ext_req = 1; bif.ext_we = 0; bif.ext_addr = 16'h0200;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk); #1;
            exp = ((i / 4) % 2 == 0) ? 2'b01 : 2'b10;
            n_cmp++;
            if (bif.owner !== exp) begin
                n_err++; $display("FAIL rr_owner[%0d]: got %b want %b", i, bif.owner, exp);
            end
        end
        idle_inputs();
    endtask

    task automatic test_ext_read();
        apply_reset();
        @(negedge clk);
        bif.ext_req = 1; bif.ext_we = 0; bif.ext_addr = 16'h0100; bif.bus_rdata = 8'h5A;
        @(negedge clk); #1;
        n_cmp++;
        if ({bif.ext_gnt, bif.bus_re, bif.bus_we} !== 3'b110) begin
            n_err++; $display("FAIL extrd_strobes: got %b want 110", {bif.ext_gnt, bif.bus_re, bif.bus_we});
        end
        n_cmp++;
        if ({bif.ext_rdata, bif.cpu_rdata} !== {8'h5A, 8'h00}) begin
            n_err++; $display("FAIL extrd_rdata: got %h/%h want 5a/00", bif.ext_rdata, bif.cpu_rdata);
        end
        n_cmp++;
        if (bif.bus_addr !== 16'h0100) begin
            n_err++; $display("FAIL extrd_addr: got %h want 0100", bif.bus_addr);
        end
    endtask

    // Continues from EXT owning the bus uncontested
    task automatic test_cpu_preempt();
        @(negedge clk);
        bif.cpu_req = 1; bif.cpu_we = 0; bif.cpu_addr = 16'h0040;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            n_cmp++;
            if (bif.cpu_stall !== ((k < 4) ? 1'b1 : 1'b0)) begin
                n_err++; $display("FAIL preempt_stall[%0d]: got %b want %b", k, bif.cpu_stall, k < 4);
            end
            n_cmp++;
            if (bif.owner !== ((k < 4) ? 2'b10 : 2'b01)) begin
                n_err++; $display("FAIL preempt_owner[%0d]: got %b", k, bif.owner);
            end
        end
        idle_inputs();
    endtask

    task automatic test_burst1();
        logic [1:0] exp;
        apply_reset();
        @(negedge clk);
        bif1.cpu_req = 1; bif1.ext_req = 1; bif1.cpu_we = 1; bif1.ext_we = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            exp = (i % 2 == 0) ? 2'b01 : 2'b10;
            n_cmp++;
            if ({bif1.owner, bif1.cpu_stall} !== {exp, exp != 2'b01}) begin
                n_err++; $display("FAIL burst1[%0d]: got owner %b stall %b want %b", i, bif1.owner, bif1.cpu_stall, exp);
            end
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        apply_reset();
        @(negedge clk);
        bif.cpu_req = 1; bif.cpu_we = 1; bif.cpu_addr = 16'h0026; bif.cpu_wdata = 8'h77;
        @(negedge clk); #1;
        n_cmp++;
        if (bif.bus_we !== 1'b1) begin
            n_err++; $display("FAIL areset_pre_we: got %b want 1", bif.bus_we);
        end
        @(posedge clk); #3;
        reset = 0;
        #1;
        n_cmp++;
        if ({bif.bus_we, bif.owner} !== 3'b000) begin
            n_err++; $display("FAIL areset_drop: got we %b owner %b want 0 00", bif.bus_we, bif.owner);
        end
        @(negedge clk);
        reset = 1;
        bif.ext_req = 1; bif.ext_we = 0;
        @(negedge clk); #1;
        n_cmp++;
        if (bif.owner !== 2'b01) begin
            n_err++; $display("FAIL areset_tie: got %b want 01", bif.owner);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        logic [1:0]    e_owner;
        logic [17:0]   e_bus;
        logic [1:0]    e_ctl;
        logic [15:0]   e_rd;
        apply_reset();
        m_owner = 0; m_run = 0; m_last = 2;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            bif.cpu_req   = ($urandom_range(0, 3) != 0);
            bif.ext_req   = ($urandom_range(0, 2) != 0);
            bif.cpu_we    = 1'($urandom);
            bif.ext_we    = 1'($urandom);
            bif.cpu_addr  = 16'($urandom);
            bif.ext_addr  = 16'($urandom);
            bif.cpu_wdata = 8'($urandom);
            bif.ext_wdata = 8'($urandom);
            bif.bus_rdata = 8'($urandom);
            #1;
            e_owner = 2'(m_owner);
            e_ctl   = {bif.cpu_req && (m_owner != 1), m_owner == 2};
            e_bus   = '0;
            e_rd    = '0;
            if (m_owner == 1) begin
                e_bus = {bif.cpu_req & bif.cpu_we, bif.cpu_req & ~bif.cpu_we, bif.cpu_addr};
                e_rd  = {bif.bus_rdata, 8'h00};
            end else if (m_owner == 2) begin
                e_bus = {bif.ext_req & bif.ext_we, bif.ext_req & ~bif.ext_we, bif.ext_addr};
                e_rd  = {8'h00, bif.bus_rdata};
            end
            n_cmp++;
            if (bif.owner !== e_owner) begin
                n_err++; $display("FAIL rnd_owner[%0d]: got %b want %b", c, bif.owner, e_owner);
            end
            n_cmp++;
            if ({bif.cpu_stall, bif.ext_gnt} !== e_ctl) begin
                n_err++; $display("FAIL rnd_stall_gnt[%0d]: got %b want %b", c, {bif.cpu_stall, bif.ext_gnt}, e_ctl);
            end
            n_cmp++;
            if ({bif.bus_we, bif.bus_re, bif.bus_addr} !== e_bus) begin
                n_err++; $display("FAIL rnd_bus[%0d]: got %h want %h", c, {bif.bus_we, bif.bus_re, bif.bus_addr}, e_bus);
            end
            n_cmp++;
            if ({bif.cpu_rdata, bif.ext_rdata} !== e_rd) begin
                n_err++; $display("FAIL rnd_rdata[%0d]: got %h want %h", c, {bif.cpu_rdata, bif.ext_rdata}, e_rd);
            end
            if (m_owner != 0) begin
                n_cmp++;
                if (bif.bus_wdata !== ((m_owner == 1) ? bif.cpu_wdata : bif.ext_wdata)) begin
                    n_err++; $display("FAIL rnd_wdata[%0d]: got %h", c, bif.bus_wdata);
                end
            end
            @(posedge clk);
            model_step(bif.cpu_req, bif.ext_req);
        end
        idle_inputs();
    endtask

    initial begin
        clk   = 0;
        reset = 0;
        n_cmp = 0;
        n_err = 0;
        idle_inputs();
        test_reset();
        test_cpu_write();
        test_round_robin();
        test_ext_read();
        test_cpu_preempt();
        test_burst1();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
